cache_line_fill: RTL
====================

Name: cache_line_fill

Overview:
- Initiator-side controller for the cache data array; it is the only agent that drives the array's index/we/din and reads its dout.
- On a miss from the L1 controller it optionally writes back the dirty victim line word by word to the next memory level, then fetches the new line and writes it into the array one word per cycle.
- Sits between the L1 tag/control logic, the cache data array, and the next-level memory port.

Parameters:
- ENTRY_WIDTH, 10, array index width (word granularity)
- DATA_WIDTH, `_4B (32), word width in bits
- WORDS_PER_LINE, 4, words per cache line (power of two)
- WORD_SEL_WIDTH, 2, log2(WORDS_PER_LINE)
- ADDR_WIDTH, 32, memory byte address width

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  miss request valid
- req_ready  out  1  controller idle, able to accept a request
- req_wb  in  1  victim line is dirty; write back before fill
- req_line  in  ENTRY_WIDTH-WORD_SEL_WIDTH  line number in array
- req_fill_addr  in  ADDR_WIDTH  byte address of line to fetch
- req_wb_addr  in  ADDR_WIDTH  byte address of victim line
- done  out  1  one-cycle pulse: line fill complete
- arr_index  out  ENTRY_WIDTH  array word index {line, word}
- arr_we  out  1  array write enable
- arr_din  out  DATA_WIDTH  array write data
- arr_dout  in  DATA_WIDTH  array read data (combinational from arr_index)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_write  out  1  1 = word write, 0 = line read
- mem_req_addr  out  ADDR_WIDTH  request byte address
- mem_req_wdata  out  DATA_WIDTH  write data
- mem_rsp_valid  in  1  read response beat valid (no backpressure)
- mem_rsp_data  in  DATA_WIDTH  read response word

Behaviour:
- Reset (async, immediate): state IDLE, word counter 0, arr_we=0, arr_index=0, arr_din=0, done=0, mem_req_valid=0, mem_req_write=0, mem_req_addr=0. req_ready=1 once in IDLE.
- arr_index, arr_din, arr_we and done are registered and glitch-free. The array is level-sensitive, so arr_index and arr_din are held stable whenever arr_we=1.
- FSM states: IDLE, WB_SEND, FILL_REQ, FILL_RECV, DONE.
- IDLE:
  - req_ready=1.
  - When req_valid=1: capture line and addresses, clearing the low log2(WORDS_PER_LINE*DATA_WIDTH/8) address bits. Set arr_index<={line,0}, cnt<=0.
  - Next state: WB_SEND if req_wb=1, else FILL_REQ.
- WB_SEND:
  - Drive mem_req_valid=1, mem_req_write=1, mem_req_addr=wb_addr+cnt*(DATA_WIDTH/8) (modulo 2^ADDR_WIDTH), mem_req_wdata=arr_dout (combinational pass-through).
  - All of these hold while mem_req_ready=0.
  - On handshake: cnt++ and arr_index<={line,cnt+1}. On the last word: cnt<=0, go to FILL_REQ.
- FILL_REQ:
  - mem_req_valid=1, mem_req_write=0, mem_req_addr=fill_addr. Held until mem_req_ready.
  - On handshake: go to FILL_RECV.
- FILL_RECV:
  - mem_req_valid=0.
  - On each mem_rsp_valid: next cycle arr_we=1, arr_index={line,cnt}, arr_din=mem_rsp_data; cnt++.
  - On the last beat: go to DONE.
  - In cycles without a beat, arr_we=0.
- DONE:
  - One cycle; arr_we is high here for the final word.
  - Next cycle: done=1 for one cycle, state IDLE, req_ready=1.
  - Latency: last beat at cycle t -> final array write at t+1 -> done at t+2.
- A new request may be accepted in the same cycle done=1.
- mem_rsp_valid outside FILL_RECV is a protocol error and is ignored; no array write occurs.
- Reset mid-operation aborts the transaction and leaves a partially written line. The L1 controller must invalidate that line; this block keeps no record of it.

Decomposition:
- FSM state encoding and the WORDS_PER_LINE/WORD_SEL_WIDTH defaults go in define.v beside the existing size constants.
- Single module; no sub-module is natural.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release req_ready=1, done=0.
- Clean miss: line=5, fill_addr=0x1000, wb=0; memory returns A0..A3 on consecutive cycles.
  - Required: a single read request, addr 0x1000, write=0.
  - Array writes to index 20..23 with A0..A3, one per cycle.
  - done exactly 2 cycles after the last beat.
- Dirty miss with stalls: array 20..23 preloaded D0..D3, wb_addr=0x2000, mem_req_ready low 2 of every 3 cycles.
  - Required: 4 writes at 0x2000/4/8/C carrying D0..D3, addr and data stable during stalls.
  - Then the read of fill_addr, then the fill.
- Gapped response: rsp beats every third cycle -> exactly 4 single-cycle arr_we pulses with correct index/data; no extra writes.
- Reset after 2 fill beats: outputs clear immediately. A new clean request to line 7 then completes normally, writing index 28..31.
- Back-to-back requests: req_valid held high -> second request accepted in the done cycle and its memory request issues the next cycle; a spurious mem_rsp_valid in IDLE causes no arr_we.

Source files
------------

// File: rtl/cache_line_fill_pkg.sv
// ----------------------------------------------------------------------------
// cache_line_fill_pkg
//   Shared size defaults, the line-fill FSM state encoding and a small helper
//   used to derive the line byte-offset width.
// ----------------------------------------------------------------------------
package cache_line_fill_pkg;

  localparam int ENTRY_WIDTH_DEF    = 10;  // array index width, word granularity
  localparam int DATA_WIDTH_DEF     = 32;  // word width in bits
  localparam int WORDS_PER_LINE_DEF = 4;   // words per cache line, power of two
  localparam int WORD_SEL_WIDTH_DEF = 2;   // log2(WORDS_PER_LINE)
  localparam int ADDR_WIDTH_DEF     = 32;  // memory byte address width

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WB_SEND   = 3'd1,
    ST_FILL_REQ  = 3'd2,
    ST_FILL_RECV = 3'd3,
    ST_DONE      = 3'd4
  } fill_state_e;

  // Number of byte-address bits that lie inside one cache line.
  function automatic int line_offset_bits(input int words, input int data_width);
    return $clog2(words * data_width / 8);
  endfunction

endpackage

// File: rtl/cache_line_fill.sv
// ----------------------------------------------------------------------------
// cache_line_fill
//   Initiator-side controller for the cache data array. On a miss it
//   optionally writes the dirty victim line back to the next memory level one
//   word per handshake, then issues a single line read and writes the
//   returned beats into the array, one word per cycle.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  miss request handshake (ready = idle)
//   req_wb               victim is dirty, write it back first
//   req_line             line number in the array
//   req_fill_addr        byte address of the line to fetch
//   req_wb_addr          byte address of the victim line
//   done                 one-cycle pulse after the last array write
//   arr_index/we/din     registered array write/read port
//   arr_dout             array read data, combinational from arr_index
//   mem_req_*            next-level request channel (valid/ready)
//   mem_rsp_valid/data   read response beats, no backpressure
//
// States
//   state        | meaning
//   ST_IDLE      | waiting for a miss, req_ready=1
//   ST_WB_SEND   | writing victim words to memory, one per handshake
//   ST_FILL_REQ  | presenting the line read request
//   ST_FILL_RECV | collecting response beats into the array
//   ST_DONE      | final array write in progress; done pulses next cycle
// ----------------------------------------------------------------------------
module cache_line_fill
  import cache_line_fill_pkg::*;
#(
  parameter int ENTRY_WIDTH    = ENTRY_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int WORD_SEL_WIDTH = WORD_SEL_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_wb,
  input  logic [ENTRY_WIDTH-WORD_SEL_WIDTH-1:0] req_line,
  input  logic [ADDR_WIDTH-1:0]                 req_fill_addr,
  input  logic [ADDR_WIDTH-1:0]                 req_wb_addr,
  output logic                                  done,
  output logic [ENTRY_WIDTH-1:0]                arr_index,
  output logic                                  arr_we,
  output logic [DATA_WIDTH-1:0]                 arr_din,
  input  logic [DATA_WIDTH-1:0]                 arr_dout,
  output logic                                  mem_req_valid,
  input  logic                                  mem_req_ready,
  output logic                                  mem_req_write,
  output logic [ADDR_WIDTH-1:0]                 mem_req_addr,
  output logic [DATA_WIDTH-1:0]                 mem_req_wdata,
  input  logic                                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]                 mem_rsp_data
);

  localparam int LINE_WIDTH     = ENTRY_WIDTH - WORD_SEL_WIDTH;
  localparam int BYTE_SEL_WIDTH = $clog2(DATA_WIDTH / 8);
  localparam int LINE_OFS_WIDTH = line_offset_bits(WORDS_PER_LINE, DATA_WIDTH);

  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    ~((ADDR_WIDTH'(1) << LINE_OFS_WIDTH) - ADDR_WIDTH'(1));
  localparam logic [WORD_SEL_WIDTH-1:0] LAST_WORD = WORD_SEL_WIDTH'(WORDS_PER_LINE - 1);
  localparam logic [WORD_SEL_WIDTH-1:0] ONE_WORD  = WORD_SEL_WIDTH'(1);

  fill_state_e                state;
  fill_state_e                state_nxt;
  logic [WORD_SEL_WIDTH-1:0]  cnt;
  logic [LINE_WIDTH-1:0]      line_q;
  logic [ADDR_WIDTH-1:0]      fill_addr_q;
  logic [ADDR_WIDTH-1:0]      wb_addr_q;
  logic [ADDR_WIDTH-1:0]      word_ofs;
  logic                       last_word;

  assign last_word = (cnt == LAST_WORD);
  assign word_ofs  = ADDR_WIDTH'(cnt) << BYTE_SEL_WIDTH;
  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Request-channel outputs come straight from the state register and the
  // captured addresses, so they cannot change while the memory stalls.
  // The handshake is qualified with mem_req_ready alone: valid is implied by
  // the state, which keeps the ready->valid path free of loops.
  always_comb begin
    state_nxt     = state;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = req_wb ? ST_WB_SEND : ST_FILL_REQ;
        end
      end
      ST_WB_SEND: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = wb_addr_q + word_ofs;
        mem_req_wdata = arr_dout;
        if (mem_req_ready && last_word) begin
          state_nxt = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = fill_addr_q;
        if (mem_req_ready) begin
          state_nxt = ST_FILL_RECV;
        end
      end
      ST_FILL_RECV: begin
        if (mem_rsp_valid && last_word) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Array port and word counter. arr_index/arr_din only move on the edge that
  // also sets or clears arr_we, so they are steady for the whole write cycle.
  // The counter is a power-of-two wide, so the increment after the last word
  // wraps it back to zero for the next phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      line_q      <= '0;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      arr_index   <= '0;
      arr_din     <= '0;
      arr_we      <= 1'b0;
      done        <= 1'b0;
    end else begin
      arr_we <= 1'b0;
      done   <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            line_q      <= req_line;
            fill_addr_q <= req_fill_addr & LINE_MASK;
            wb_addr_q   <= req_wb_addr & LINE_MASK;
            arr_index   <= {req_line, {WORD_SEL_WIDTH{1'b0}}};
            cnt         <= '0;
          end
        end
        ST_WB_SEND: begin
          if (mem_req_ready) begin
            cnt       <= cnt + ONE_WORD;
            arr_index <= {line_q, cnt + ONE_WORD};
          end
        end
        ST_FILL_RECV: begin
          if (mem_rsp_valid) begin
            arr_we    <= 1'b1;
            arr_index <= {line_q, cnt};
            arr_din   <= mem_rsp_data;
            cnt       <= cnt + ONE_WORD;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
